// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with a valid/ready load
// handshake, bit-rate enable, back-to-back word support and an end-of-word
// pulse. Bit order is selected by LSB_FIRST.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_sout, r_sout_valid, r_done;

  logic             w_last, w_accept, w_bit;
  logic [WIDTH-1:0] w_shifted;

  // Last bit of the word leaves on this edge; also the only SHIFT-state
  // edge where a following word may be taken without a gap.
  assign w_last     = (r_state == SHIFT) && (r_cnt == CW'(1)) && shift_en;
  assign load_ready = rst_n && ((r_state == IDLE) || w_last);
  assign w_accept   = load_valid && load_ready;

  assign w_bit      = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];
  assign w_shifted  = LSB_FIRST ? {1'b0, r_sreg[WIDTH-1:1]}
                                : {r_sreg[WIDTH-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: leave IDLE on accept; leave SHIFT after the last bit unless
  // a back-to-back word is taken on that same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)            w_state_nxt = SHIFT;
      SHIFT:   if (w_last && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load, shift and present bits; done marks the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        IDLE: begin
          r_sout       <= IDLE_LEVEL;
          r_sout_valid <= 1'b0;
          if (w_accept) begin
            r_sreg <= pin;
            r_cnt  <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          if (shift_en) begin
            r_sout       <= w_bit;
            r_sout_valid <= 1'b1;
            // In SHIFT an accept can only coincide with the last bit.
            if (w_accept) begin
              r_sreg <= pin;
              r_cnt  <= CW'(WIDTH);
            end else begin
              r_sreg <= w_shifted;
              r_cnt  <= r_cnt - CW'(1);
            end
          end else begin
            // Stall: hold the line, mark no new bit.
            r_sout_valid <= 1'b0;
          end
        end
        default: begin
          r_sout       <= IDLE_LEVEL;
          r_sout_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign done       = r_done;
  assign busy       = (r_state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: two instances (4-bit MSB-first idle 0,
// 8-bit LSB-first idle 1). Accepted words are expanded into an expected bit
// stream queue; a negedge monitor pops and compares each presented bit and
// checks handshake/busy/valid against the outstanding-bit count.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, lv_a, se_a, rdy_a, so_a, sv_a, bz_a, dn_a;
  logic [3:0] pin_a;
  logic       rst_b, lv_b, se_b, rdy_b, so_b, sv_b, bz_b, dn_b;
  logic [7:0] pin_b;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_a), .pin(pin_a), .load_valid(lv_a),
    .load_ready(rdy_a), .shift_en(se_a), .sout(so_a), .sout_valid(sv_a),
    .busy(bz_a), .done(dn_a));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_b), .pin(pin_b), .load_valid(lv_b),
    .load_ready(rdy_b), .shift_en(se_b), .sout(so_b), .sout_valid(sv_b),
    .busy(bz_b), .done(dn_b));

  // Expected stream entries: {bit, last_of_word}
  logic [1:0] qa[$];
  logic [1:0] qb[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  logic fin = 1'b0;
  logic fin_chk = 1'b0;

  logic exp_vld[2]   = '{1'b0, 1'b0};
  logic rst_prev[2]  = '{1'b1, 1'b1};
  logic prev_busy[2] = '{1'b0, 1'b0};
  logic prev_sout[2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input int id, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s u%0d @%0t: got %0d expected %0d", nm, id, $time, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic so, input logic sv, input logic bz,
                     input logic dn, input logic rdy, input logic rs,
                     input logic lv, input logic se, input logic [7:0] p);
    int         w, pend;
    logic       lsbf, idl, exp_rdy;
    logic [1:0] e;
    w    = (id == 0) ? 4 : 8;
    lsbf = (id == 1);
    idl  = (id == 1);
    if (rst_prev[id]) begin
      chk("reset_sout", id, so, idl);
      chk("reset_busy", id, bz, 0);
      chk("reset_done", id, dn, 0);
    end
    chk("sout_valid", id, sv, exp_vld[id]);
    if (sv) begin
      if (((id == 0) ? qa.size() : qb.size()) == 0) begin
        chk("extra_bit", id, 1, 0);
      end else begin
        e = (id == 0) ? qa.pop_front() : qb.pop_front();
        chk("bit", id, so, e[1]);
        chk("done", id, dn, e[0]);
      end
    end else begin
      chk("done_idle", id, dn, 0);
      if (!bz) chk("idle_level", id, so, idl);
      if (bz && prev_busy[id]) chk("stall_hold", id, so, prev_sout[id]);
    end
    pend    = (id == 0) ? qa.size() : qb.size();
    exp_rdy = rs && (pend == 0 || (pend == 1 && se));
    chk("load_ready", id, rdy, exp_rdy);
    chk("busy", id, bz, pend > 0);
    exp_vld[id]  = rs && se && (pend > 0);
    rst_prev[id] = !rs;
    if (!rs) begin
      if (id == 0) qa.delete(); else qb.delete();
    end else if (lv && exp_rdy) begin
      for (int k = 0; k < w; k++) begin
        e = {(lsbf ? p[k] : p[w-1-k]), (k == w - 1)};
        if (id == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
    prev_busy[id] = bz;
    prev_sout[id] = so;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, so_a, sv_a, bz_a, dn_a, rdy_a, rst_a, lv_a, se_a, {4'b0, pin_a});
      mon(1, so_b, sv_b, bz_b, dn_b, rdy_b, rst_b, lv_b, se_b, pin_b);
      if (fin && !fin_chk) begin
        chk("drain", 0, qa.size(), 0);
        chk("drain", 1, qb.size(), 0);
        fin_chk = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic r, input logic lv, input logic se, input logic [3:0] p);
    rst_a = r; lv_a = lv; se_a = se; pin_a = p;
    tick();
  endtask

  task automatic drv_b(input logic r, input logic lv, input logic se, input logic [7:0] p);
    rst_b = r; lv_b = lv; se_b = se; pin_b = p;
    tick();
  endtask

  initial begin
    // Reset with load_valid asserted on both instances.
    rst_a = 1'b0; lv_a = 1'b1; se_a = 1'b1; pin_a = 4'hF;
    rst_b = 1'b0; lv_b = 1'b1; se_b = 1'b1; pin_b = 8'hFF;
    tick();
    mon_en = 1'b1;
    tick(); tick();
    rst_a = 1'b1; lv_a = 1'b0; rst_b = 1'b1; lv_b = 1'b0;
    tick();

    // MSB-first single word.
    drv_a(1, 1, 1, 4'b1010);
    repeat (6) drv_a(1, 0, 1, 4'b0000);

    // Back-to-back: second word held on load_valid until taken.
    drv_a(1, 1, 1, 4'b1010);
    repeat (4) drv_a(1, 1, 1, 4'b0101);
    repeat (6) drv_a(1, 0, 1, 4'b0000);

    // Stall pattern 1,0,0,1,1,1 with mid-word load attempts.
    drv_a(1, 1, 1, 4'b1100);
    drv_a(1, 0, 1, 4'b0000);
    drv_a(1, 1, 0, 4'b0011);
    drv_a(1, 1, 0, 4'b0011);
    drv_a(1, 1, 1, 4'b0011);
    drv_a(1, 0, 1, 4'b0000);
    drv_a(1, 0, 1, 4'b0000);
    repeat (4) drv_a(1, 0, 1, 4'b0000);

    // LSB-first 8'hC5.
    drv_b(1, 1, 1, 8'hC5);
    repeat (10) drv_b(1, 0, 1, 8'h00);

    // Abort after two bits, then a fresh word.
    drv_b(1, 1, 1, 8'hA7);
    drv_b(1, 0, 1, 8'h00);
    drv_b(1, 0, 1, 8'h00);
    drv_b(0, 1, 1, 8'h55);
    drv_b(1, 0, 1, 8'h00);
    drv_b(1, 1, 1, 8'h3C);
    repeat (10) drv_b(1, 0, 1, 8'h00);

    // Randomised traffic on both instances together.
    for (int i = 0; i < 1500; i++) begin
      rst_a = ($urandom % 97) != 0;
      lv_a  = ($urandom % 3) != 0;
      se_a  = ($urandom % 4) != 0;
      pin_a = 4'($urandom);
      rst_b = ($urandom % 97) != 0;
      lv_b  = ($urandom % 3) != 0;
      se_b  = ($urandom % 4) != 0;
      pin_b = 8'($urandom);
      tick();
    end

    // Drain.
    rst_a = 1'b1; lv_a = 1'b0; se_a = 1'b1;
    rst_b = 1'b1; lv_b = 1'b0; se_b = 1'b1;
    repeat (12) tick();
    fin = 1'b1;
    repeat (3) tick();
    if (!fin_chk) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_check: got not-run expected run");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer: the next generation of the team's 4-bit PISO shifter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, MSB-first or LSB-first. It supports back-to-back words with no idle gap, an external bit-rate enable, and an end-of-word pulse. It sits between a parallel data source (register file or FIFO) and a single-wire serial link or a slower serial peripheral.

## Interface
- WIDTH, 8: word length in bits; legal range is WIDTH >= 2.
- LSB_FIRST, 0: 0 shifts the MSB out first; 1 shifts the LSB out first.
- IDLE_LEVEL, 1'b0: value driven on sout whenever no bit is being presented.

Reset is synchronous and active-low. The block uses one clock, clk, and one reset, rst_n.
- clk  input  1  single clock; everything changes on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- pin  input  WIDTH  parallel word; sampled only on the accepting edge.
- load_valid  input  1  source has a word on pin.
- load_ready  output  1  block can accept a word this cycle (combinational).
- shift_en  input  1  bit-rate enable; a bit advances only on edges where it is 1.
- sout  output  1  serial data (registered).
- sout_valid  output  1  high for one cycle per newly presented bit (registered).
- busy  output  1  a word is in flight (state SHIFT).
- done  output  1  one-cycle pulse coincident with the last bit of a word.

## Operation
- Registers:
  - shift register sreg[WIDTH-1:0].
  - bit counter cnt, $clog2(WIDTH+1) bits, holding bits remaining.
  - state in {IDLE, SHIFT}.
- Handshake: a word is accepted on an edge where load_valid && load_ready. While load_ready=0, load_valid is ignored and pin is don't-care.
- load_ready is defined as rst_n && ((state==IDLE) || (state==SHIFT && cnt==1 && shift_en)).
- IDLE:
  - On accept: sreg <= pin, cnt <= WIDTH, go to SHIFT.
  - sout = IDLE_LEVEL, sout_valid = 0.
- SHIFT, on an edge with shift_en=1:
  - Emit the next bit: sreg[WIDTH-1] if LSB_FIRST=0, else sreg[0]. sout <= that bit, sout_valid <= 1.
  - Shift sreg toward the emitting end, filling with 0. cnt <= cnt-1.
- SHIFT, on an edge with shift_en=0: sout holds its value, sout_valid <= 0, sreg and cnt hold.
- Last bit (cnt==1 && shift_en):
  - done <= 1.
  - If a word is accepted on the same edge, load the new word with cnt <= WIDTH and stay in SHIFT (back-to-back).
  - Otherwise go to IDLE.
- Return to idle: on the first edge in IDLE after the last bit, sout <= IDLE_LEVEL and sout_valid <= 0.
- Reset (rst_n=0 at an edge):
  - state=IDLE, cnt=0, sreg=0.
  - sout=IDLE_LEVEL, sout_valid=0, busy=0, done=0.
  - load_ready=0 while rst_n=0.
  - Reset mid-word aborts the word: no further bits and no done.

## Timing
- Edge 0 accepts the word.
- With shift_en held at 1:
  - Bit k (k=0..WIDTH-1) appears on sout after edge k+1, with sout_valid=1.
  - done=1 during the same cycle as bit WIDTH-1, after edge WIDTH.
- Latency from acceptance to the first bit is 1 enabled edge.
- Total is WIDTH enabled edges per word.
- Each edge with shift_en=0 stretches the word by one cycle. sout is stable during the stall.
- Back-to-back: if load_valid=1 when cnt==1 && shift_en, the first bit of the next word follows on the next enabled edge. sout_valid stays 1 continuously at shift_en=1 with no gap cycle.
- busy rises after edge 0. It falls after the last-bit edge, unless a back-to-back word was accepted.
- done is never high for more than one cycle per word. It is never asserted after a reset abort.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with load_valid=1, then release. Required response:
  - During reset: sout=IDLE_LEVEL, sout_valid=0, busy=0, done=0, load_ready=0.
  - First cycle after release: load_ready=1.
- MSB-first, WIDTH=4, pin=4'b1010, shift_en=1, with a 1-cycle load_valid pulse. Required response:
  - sout = 1,0,1,0 after edges 1..4, with sout_valid=1 on all four.
  - done=1 only after edge 4.
  - sout returns to 0 after edge 5.
- LSB_FIRST=1, WIDTH=8, pin=8'hC5. Required response:
  - sout = 1,0,1,0,0,0,1,1.
  - done on the 8th bit.
- Back-to-back, WIDTH=4: pin=4'b1010 accepted, then pin=4'b0101 presented with load_valid held. Required response:
  - Second word accepted on the 4th-bit edge.
  - sout = 1,0,1,0,0,1,0,1 over 8 consecutive cycles, with sout_valid continuously 1 and done high at cycles 4 and 8.
- Stall: shift_en = 1,0,0,1,1,1 during a 4-bit word. Required response:
  - sout holds the first bit for 3 cycles, with sout_valid=0 in the two stall cycles.
  - Word completes after 6 edges.
  - load_valid asserted mid-word with different pin data is ignored and does not corrupt the word.
- Abort: assert rst_n=0 after bit 2 of an 8-bit word. Required response:
  - Next cycle: sout=IDLE_LEVEL, busy=0, no done pulse.
  - A fresh word sent after release serialises correctly.
